// File: rtl/rand_cell_picker.sv
// rand_cell_picker
//   Turns the free-running 10-bit LFSR word into discrete picks in
//   [0, RANGE-1]. It waits a randomized gap, then draws candidates by
//   rejection sampling, and offers each pick on a valid/ready handshake.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   en           run enable (ignored while a pick is being offered)
//   random_num   LFSR word [10:1], advances every cycle
//   sample_valid pick available
//   sample_ready consumer accepts pick
//   sample_value current pick, held stable while sample_valid is high
//   busy         high whenever the FSM is not IDLE
//
// Optional feature
//   RAND_CELL_PICKER_NO_REPEAT_EN : a candidate equal to the previous pick
//   is rejected as well, so two consecutive picks always differ.
module rand_cell_picker #(
    parameter int RANGE     = 9,
    parameter int MASK_W    = 4,
    parameter int OUT_W     = 4,
    parameter int GAP_MIN   = 16,
    parameter int MAX_TRIES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [10:1]      random_num,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic [OUT_W-1:0] sample_value,
    output logic             busy
);

    // gap_cnt must hold GAP_MIN+14 (largest L-1)
    localparam int GAP_W = $clog2(GAP_MIN + 16);
    localparam int TRY_W = $clog2(MAX_TRIES) + 1;

    typedef enum logic [1:0] {IDLE, GAP, DRAW, PRESENT} state_t;

    state_t            state, state_nx;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_nx;
    logic [TRY_W-1:0]  tries, tries_nx;
    logic [OUT_W-1:0]  last_value, last_nx;
    logic [OUT_W-1:0]  value_q, value_nx;
    logic              valid_q, valid_nx;
    logic              busy_q;

    logic [MASK_W-1:0] cand;
    logic              cand_in_range;
    logic              reject;
    logic              last_try;
    logic [OUT_W-1:0]  fallback;
    logic [GAP_W-1:0]  gap_load;

    // Bits of the LFSR word that this configuration does not consume.
    logic unused_bits;
    assign unused_bits = ^random_num;

    assign cand          = random_num[MASK_W:1];
    assign cand_in_range = (32'(cand) < 32'(RANGE));

`ifdef RAND_CELL_PICKER_NO_REPEAT_EN
    assign reject = !cand_in_range || (OUT_W'(cand) == last_value);
`else
    assign reject = !cand_in_range;
`endif

    assign last_try = (tries == TRY_W'(MAX_TRIES - 1));
    // Step past the previous pick; always differs from it, so it also
    // satisfies the no-repeat rule when that feature is enabled.
    assign fallback = (last_value == OUT_W'(RANGE - 1)) ? '0
                                                        : last_value + OUT_W'(1);
    // Counter is loaded with L-1 so the GAP state lasts exactly L cycles.
    assign gap_load = GAP_W'(GAP_MIN - 1) + GAP_W'(random_num[10:7]);

    always_comb begin
        state_nx   = state;
        gap_cnt_nx = gap_cnt;
        tries_nx   = tries;
        last_nx    = last_value;
        value_nx   = value_q;
        valid_nx   = valid_q;
        case (state)
            IDLE: begin
                if (en) begin
                    gap_cnt_nx = gap_load;
                    state_nx   = GAP;
                end
            end
            GAP: begin
                if (!en) begin
                    state_nx = IDLE;
                    tries_nx = '0;
                end else if (gap_cnt == '0) begin
                    state_nx = DRAW;
                end else begin
                    gap_cnt_nx = gap_cnt - GAP_W'(1);
                end
            end
            DRAW: begin
                if (!en) begin
                    state_nx = IDLE;
                    tries_nx = '0;
                end else if (!reject) begin
                    value_nx = OUT_W'(cand);
                    valid_nx = 1'b1;
                    tries_nx = '0;
                    state_nx = PRESENT;
                end else if (last_try) begin
                    value_nx = fallback;
                    valid_nx = 1'b1;
                    tries_nx = '0;
                    state_nx = PRESENT;
                end else begin
                    tries_nx = tries + TRY_W'(1);
                end
            end
            PRESENT: begin
                // en is deliberately ignored: an offered pick is never dropped.
                if (valid_q && sample_ready) begin
                    last_nx  = value_q;
                    valid_nx = 1'b0;
                    if (en) begin
                        gap_cnt_nx = gap_load;
                        state_nx   = GAP;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            tries      <= '0;
            last_value <= '0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_nx;
            gap_cnt    <= gap_cnt_nx;
            tries      <= tries_nx;
            last_value <= last_nx;
            value_q    <= value_nx;
            valid_q    <= valid_nx;
            busy_q     <= (state_nx != IDLE);
        end
    end

    assign sample_valid = valid_q;
    assign sample_value = value_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_rand_cell_picker.sv
// Self-checking bench for rand_cell_picker: directed scenarios with literal
// expectations plus a long randomized run, all compared every cycle against
// a behavioural model of the pick process.
module tb_rand_cell_picker;

    localparam int RANGE     = 9;
    localparam int MASK_W    = 4;
    localparam int OUT_W     = 4;
    localparam int GAP_MIN   = 16;
    localparam int MAX_TRIES = 8;

    logic             clk = 1'b0;
    logic             rst_i = 1'b0;
    logic             en_i = 1'b0;
    logic             rdy_i = 1'b0;
    logic [10:1]      rn = '0;
    logic             sample_valid;
    logic [OUT_W-1:0] sample_value;
    logic             busy;

    int n_chk = 0;
    int n_pass = 0;

    // model: pending pick, remaining gap cycles, drawing flag, rejects so far
    bit m_pend, m_draw;
    int m_gap, m_val, m_last, m_rej;

    always #5 clk = ~clk;

    rand_cell_picker #(
        .RANGE(RANGE), .MASK_W(MASK_W), .OUT_W(OUT_W),
        .GAP_MIN(GAP_MIN), .MAX_TRIES(MAX_TRIES)
    ) dut (
        .clk(clk), .rst(rst_i), .en(en_i), .random_num(rn),
        .sample_valid(sample_valid), .sample_ready(rdy_i),
        .sample_value(sample_value), .busy(busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Advance the model by one clock using the inputs presented this cycle.
    task automatic model_tick();
        int c;
        bit bad;
        if (!rst_i) begin
            m_pend = 0; m_draw = 0; m_gap = 0; m_val = 0; m_last = 0; m_rej = 0;
        end else if (m_pend) begin
            if (rdy_i) begin
                m_last = m_val;
                m_pend = 0;
                if (en_i) m_gap = GAP_MIN + int'(rn[10:7]);
            end
        end else if (m_gap > 0) begin
            if (!en_i) m_gap = 0;
            else begin
                m_gap--;
                if (m_gap == 0) m_draw = 1;
            end
        end else if (m_draw) begin
            if (!en_i) begin
                m_draw = 0; m_rej = 0;
            end else begin
                c = int'(rn) & ((1 << MASK_W) - 1);
                bad = (c >= RANGE);
`ifdef RAND_CELL_PICKER_NO_REPEAT_EN
                bad = bad || (c == m_last);
`endif
                if (!bad) begin
                    m_val = c; m_pend = 1; m_draw = 0; m_rej = 0;
                end else if (m_rej + 1 >= MAX_TRIES) begin
                    m_val = (m_last + 1) % RANGE; m_pend = 1; m_draw = 0; m_rej = 0;
                end else begin
                    m_rej++;
                end
            end
        end else if (en_i) begin
            m_gap = GAP_MIN + int'(rn[10:7]);
        end
    endtask

    // One clock: update model, take the edge, compare all outputs.
    task automatic step();
        model_tick();
        @(posedge clk);
        #1;
        chk("valid", int'(sample_valid), int'(m_pend));
        chk("value", int'(sample_value), m_val);
        chk("busy", int'(busy), int'(m_pend || m_gap > 0 || m_draw));
    endtask

    // Run (en=1) until the design is drawing candidates.
    task automatic go_draw();
        int n = 0;
        en_i = 1; rdy_i = 0;
        while (!m_draw && n < 100) begin
            rn = 10'($urandom);
            step();
            n++;
        end
        if (!m_draw) chk("draw_timeout", 0, 1);
    endtask

    // One DRAW cycle with the candidate bits forced to v.
    task automatic draw1(input int v);
        en_i = 1;
        rn = 10'(($urandom & 32'h3F0) | 32'(v));
        step();
    endtask

    task automatic accept(input bit en_after);
        en_i = en_after; rdy_i = 1; rn = 10'($urandom);
        step();
        rdy_i = 0;
    endtask

    initial begin
        int n;
        int held;

        // reset
        rst_i = 0; en_i = 0; rdy_i = 0;
        step(); step();
        chk("rst_valid", int'(sample_valid), 0);
        chk("rst_value", int'(sample_value), 0);
        chk("rst_busy", int'(busy), 0);
        rst_i = 1;
        step();

        // gap timing: L = 16 + 3 = 19, then first draw sees candidate 5
        en_i = 1; rn = 10'b0011_000101;
        step();
        chk("gap_busy", int'(busy), 1);
        n = 0;
        while (!sample_valid && n < 40) begin step(); n++; end
        chk("gap_to_valid", n, 20);
        chk("first_pick", int'(sample_value), 5);
        accept(1);

        // rejection: 12, 15, 9 rejected, 3 accepted
        go_draw();
        draw1(12); chk("rej12", int'(sample_valid), 0);
        draw1(15); chk("rej15", int'(sample_valid), 0);
        draw1(9);  chk("rej9", int'(sample_valid), 0);
        draw1(3);
        chk("acc_valid", int'(sample_valid), 1);
        chk("acc_value", int'(sample_value), 3);
        accept(1);

        // fallback from last_value=8 wraps to 0
        go_draw(); draw1(8);
        chk("pick8", int'(sample_value), 8);
        accept(1);
        go_draw();
        repeat (MAX_TRIES - 1) draw1(15);
        chk("fb_wait", int'(sample_valid), 0);
        draw1(15);
        chk("fb_valid", int'(sample_valid), 1);
        chk("fb_wrap", int'(sample_value), 0);
        accept(1);

        // fallback from last_value=4 gives 5
        go_draw(); draw1(4);
        chk("pick4", int'(sample_value), 4);
        accept(1);
        go_draw();
        repeat (MAX_TRIES) draw1(15);
        chk("fb_inc", int'(sample_value), 5);
        accept(1);

        // repeat handling with last_value=5
        go_draw();
        draw1(5);
`ifdef RAND_CELL_PICKER_NO_REPEAT_EN
        chk("norep_rej", int'(sample_valid), 0);
        draw1(2);
        chk("norep_val", int'(sample_value), 2);
`else
        chk("rep_valid", int'(sample_valid), 1);
        chk("rep_val", int'(sample_value), 5);
`endif

        // backpressure with en toggling, release with en=1
        held = int'(sample_value);
        repeat (10) begin
            rdy_i = 0; en_i = 1'($urandom); rn = 10'($urandom);
            step();
            chk("bp_valid", int'(sample_valid), 1);
            chk("bp_hold", int'(sample_value), held);
        end
        accept(1);
        chk("rel_valid", int'(sample_valid), 0);
        chk("rel_busy_en1", int'(busy), 1);

        // backpressure then release with en=0
        go_draw(); draw1(1);
        repeat (10) begin
            rdy_i = 0; en_i = 1'($urandom); rn = 10'($urandom);
            step();
            chk("bp2_hold", int'(sample_value), 1);
        end
        accept(0);
        chk("rel_busy_en0", int'(busy), 0);

        // reset while a pick is pending
        go_draw(); draw1(7);
        chk("pend_valid", int'(sample_valid), 1);
        rdy_i = 0; rst_i = 0;
        step();
        chk("mid_rst_valid", int'(sample_valid), 0);
        chk("mid_rst_value", int'(sample_value), 0);
        chk("mid_rst_busy", int'(busy), 0);
        step();
        rst_i = 1; en_i = 1;
        step();
        chk("post_rst_busy", int'(busy), 1);

        // randomized run
        for (int i = 0; i < 4000; i++) begin
            rst_i = ($urandom_range(0, 299) != 0);
            en_i  = ($urandom_range(0, 9) != 0);
            rdy_i = 1'($urandom);
            rn    = 10'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rand_cell_picker.md
Name: rand_cell_picker

Overview:
- Consumer stage directly downstream of the 10-bit LFSR.
- Turns the free-running pseudo-random word into discrete picks in [0, RANGE-1] using rejection sampling.
- Spaces successive picks by a randomized gap.
- Presents each pick on a valid/ready handshake to game/control logic, e.g. to choose which cell/target activates next.

Parameters:
- RANGE, 9, number of legal pick values (2..16).
- MASK_W, 4, candidate bits taken from random_num[MASK_W:1]; must satisfy 2^MASK_W >= RANGE.
- OUT_W, 4, width of sample_value; must be >= MASK_W.
- GAP_MIN, 16, minimum gap length in cycles (>= 1).
- MAX_TRIES, 8, rejected draws allowed before fallback (>= 1).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-low reset; sampled on posedge clk.
- en, input, 1, run enable.
- random_num, input, [10:1], LFSR word; advances every cycle.
- sample_valid, output, 1, pick available.
- sample_ready, input, 1, consumer accepts pick.
- sample_value, output, OUT_W, current pick.
- busy, output, 1, high whenever state != IDLE.

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE; sample_valid=0; sample_value=0; busy=0.
  - gap_cnt=0, tries=0, last_value=0.
  - Applies in any state, including PRESENT with a pick pending; the pending pick is discarded.
- All outputs are registered. The FSM has four states: IDLE, GAP, DRAW, PRESENT.
- IDLE:
  - If en=1: gap length L = GAP_MIN + random_num[10:7] (0..15 added); load gap_cnt=L-1; go to GAP.
  - Otherwise stay.
- GAP:
  - Occupies exactly L cycles; gap_cnt decrements each cycle.
  - When gap_cnt==0, go to DRAW next.
  - If en=0 in any GAP cycle, go to IDLE next; tries is cleared.
- DRAW:
  - Each cycle, cand = random_num[MASK_W:1], zero-extended.
  - Accept if cand < RANGE: sample_value<=cand, sample_valid<=1, go to PRESENT. Valid is high on the cycle after the accepting DRAW cycle.
  - Reject otherwise: tries<=tries+1 and stay.
  - If the reject occurs with tries==MAX_TRIES-1, force a fallback pick instead: (last_value==RANGE-1) ? 0 : last_value+1. Then present. Worst-case DRAW length is therefore MAX_TRIES cycles.
  - tries is cleared on leaving DRAW.
  - en=0 in DRAW: go to IDLE next, no pick.
- PRESENT:
  - sample_valid=1; sample_value is held stable until the handshake (sample_valid & sample_ready at posedge).
  - en is ignored here; a pick is never dropped once offered.
  - On handshake: last_value<=sample_value; sample_valid<=0 on the next cycle.
  - Next state is GAP with a fresh L (random_num[10:7] sampled on the handshake cycle) if en=1, else IDLE.
  - Throughput: at most one pick per GAP_MIN+2 cycles.
- random_num==0 (LFSR recovery case): treated as cand=0, a legal accept. No special handling.
- Widths: cand compare is unsigned MASK_W bits. gap_cnt is wide enough for GAP_MIN+14. tries is clog2(MAX_TRIES)+1 bits.

Optional Feature:
- Macro: RAND_CELL_PICKER_NO_REPEAT_EN.
- When defined: in DRAW, cand==last_value is also a rejection, counted in tries. The fallback rule already guarantees a value different from last_value. After reset last_value=0, so a first pick of 0 is rejected.
- When undefined: repeats are allowed; only cand>=RANGE rejects.

Test Plan:
- Reset mid-PRESENT: hold sample_ready=0 with a pick pending, drive rst=0 for 2 cycles -> sample_valid=0, sample_value=0, busy=0 after the first edge. With en=1 after release, a new GAP starts.
- Gap timing: GAP_MIN=16, en=1, random_num=10'b0011_000101 in IDLE -> exactly 19 GAP cycles. Then with random_num[4:1]=5 in the first DRAW cycle -> sample_valid=1, sample_value=5 one cycle later.
- Rejection: RANGE=9; DRAW low bits 12, 15, 9, then 3 -> valid asserted after the 4th DRAW cycle; sample_value=3; tries cleared.
- Fallback: MAX_TRIES=8, last_value=8, low bits held at 15 -> after 8 DRAW cycles sample_value=0 (wraps); the same sequence with last_value=4 gives 5.
- Backpressure: sample_ready=0 for 10 cycles while en toggles -> sample_valid=1 and sample_value unchanged throughout. Then ready=1 for 1 cycle -> valid=0 next cycle; state is GAP if en=1, IDLE if en=0.
- NO_REPEAT: last_value=5; DRAW low bits 5 then 2 -> with macro, sample_value=2 after 2 DRAW cycles; without macro, sample_value=5 after 1 DRAW cycle.
